// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice reused for NIBBLES cycles.
// Optional signed-overflow output ovf_out is enabled with macro OVERFLOW_FLAG_EN.

module nibble_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s    = p ^ c[3:0];
  assign co   = c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 c_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*NIBBLES-1:0] sum_out,
  output logic                 carry_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy_out
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic                 ovf_out
`endif
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          carry_q, cout_q;
  logic [IW-1:0] idx;
  logic [3:0]    a_nib, b_nib, s_nib;
  logic          c_nib;
  logic          accept, last;

  assign accept = (state == IDLE) & in_valid;
  assign last   = (idx == IW'(NIBBLES - 1));
  assign a_nib  = a_q[4*idx +: 4];
  assign b_nib  = b_q[4*idx +: 4];

  nibble_cla4 u_cla (.a(a_nib), .b(b_nib), .ci(carry_q), .s(s_nib), .co(c_nib));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy_out  = (state == RUN);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      a_q     <= a_in;
      b_q     <= b_in;
      carry_q <= c_in;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else if (state == RUN) begin
      sum_q[4*idx +: 4] <= s_nib;
      carry_q           <= c_nib;
      idx               <= idx + IW'(1);
      if (last) cout_q <= c_nib;
    end
  end

  assign sum_out   = sum_q;
  assign carry_out = cout_q;

`ifdef OVERFLOW_FLAG_EN
  // Carry into bit 3 of the MSB nibble recovered as s ^ a ^ b at that bit.
  logic ovf_q;
  always_ff @(posedge clk_in) begin
    if (rst_in)                    ovf_q <= 1'b0;
    else if (accept)               ovf_q <= 1'b0;
    else if ((state == RUN) && last) ovf_q <= s_nib[3] ^ a_nib[3] ^ b_nib[3] ^ c_nib;
  end
  assign ovf_out = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4), one task per scenario.

module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk_in = 1'b0;
  logic         rst_in, c_in, in_valid, in_ready, carry_out, out_valid, out_ready, busy_out;
  logic [W-1:0] a_in, b_in, sum_out;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf_out;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .in_valid(in_valid), .in_ready(in_ready), .sum_out(sum_out), .carry_out(carry_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy_out(busy_out)
`ifdef OVERFLOW_FLAG_EN
    , .ovf_out(ovf_out)
`endif
  );

  // Stimulus only: present one operand set, then wait (bounded) for out_valid.
  // lat = cycles from the accepting edge to out_valid, -1 on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output int lat);
    a_in = a; b_in = b; c_in = c; in_valid = 1'b1;
    @(negedge clk_in);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk_in);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset;
    rst_in = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy_out !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
    checks++; if (sum_out !== 16'h0)  begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum_out); end
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
`ifdef OVERFLOW_FLAG_EN
    checks++; if (ovf_out !== 1'b0)   begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_out); end
`endif
    rst_in = 1'b0;
  endtask

  task automatic test_wrap;
    int lat;
    out_ready = 1'b1;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if (lat != 4)            begin failures++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
    checks++; if (sum_out !== 16'h0000) begin failures++; $display("FAIL wrap_sum got=%h exp=0000", sum_out); end
    checks++; if (carry_out !== 1'b1)  begin failures++; $display("FAIL wrap_carry got=%b exp=1", carry_out); end
    @(negedge clk_in);
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL wrap_one_valid_cycle got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL wrap_idle_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_carry_in;
    int lat;
    out_ready = 1'b1;
    a_in = 16'h1234; b_in = 16'h4321; c_in = 1'b1; in_valid = 1'b1;
    @(negedge clk_in);
    in_valid = 1'b0;
    @(negedge clk_in);
    // After the first RUN edge only nibble 0 (4+1+1) has been written.
    checks++; if (sum_out !== 16'h0006) begin failures++; $display("FAIL cin_partial_sum got=%h exp=0006", sum_out); end
    checks++; if (busy_out !== 1'b1)    begin failures++; $display("FAIL cin_busy got=%b exp=1", busy_out); end
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk_in); lat++; end
    checks++; if (lat != 4)             begin failures++; $display("FAIL cin_latency got=%0d exp=4", lat); end
    checks++; if (sum_out !== 16'h5556) begin failures++; $display("FAIL cin_sum got=%h exp=5556", sum_out); end
    checks++; if (carry_out !== 1'b0)   begin failures++; $display("FAIL cin_carry got=%b exp=0", carry_out); end
    @(negedge clk_in);
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    run_op(16'h9000, 16'h8001, 1'b0, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    a_in = 16'h1111; b_in = 16'h1111; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      checks++; if (out_valid !== 1'b1)   begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
      checks++; if (sum_out !== 16'h1001) begin failures++; $display("FAIL bp_sum cyc=%0d got=%h exp=1001", i, sum_out); end
      checks++; if (carry_out !== 1'b1)   begin failures++; $display("FAIL bp_carry cyc=%0d got=%b exp=1", i, carry_out); end
      checks++; if (in_ready !== 1'b0)    begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk_in);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_abort;
    int lat;
    out_ready = 1'b1;
    a_in = 16'h1111; b_in = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
    @(negedge clk_in);
    in_valid = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy_out !== 1'b0)  begin failures++; $display("FAIL abort_busy got=%b exp=0", busy_out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", out_valid); end
    checks++; if (sum_out !== 16'h0)  begin failures++; $display("FAIL abort_sum got=%h exp=0000", sum_out); end
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL abort_carry got=%b exp=0", carry_out); end
    rst_in = 1'b0;
    run_op(16'h0F0F, 16'h00F1, 1'b0, lat);
    checks++; if (lat != 4)             begin failures++; $display("FAIL abort_new_latency got=%0d exp=4", lat); end
    checks++; if (sum_out !== 16'h1000) begin failures++; $display("FAIL abort_new_sum got=%h exp=1000", sum_out); end
    checks++; if (carry_out !== 1'b0)   begin failures++; $display("FAIL abort_new_carry got=%b exp=0", carry_out); end
    @(negedge clk_in);
  endtask

  task automatic test_ignore_in_valid;
    int lat;
    out_ready = 1'b1;
    a_in = 16'h0001; b_in = 16'h0002; c_in = 1'b0; in_valid = 1'b1;
    @(negedge clk_in);
    a_in = 16'hFFFF; b_in = 16'hFFFF; c_in = 1'b1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ign_in_ready got=%b exp=0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk_in); lat++; end
    in_valid = 1'b0;
    checks++; if (lat != 4)             begin failures++; $display("FAIL ign_latency got=%0d exp=4", lat); end
    checks++; if (sum_out !== 16'h0003) begin failures++; $display("FAIL ign_sum got=%h exp=0003", sum_out); end
    checks++; if (carry_out !== 1'b0)   begin failures++; $display("FAIL ign_carry got=%b exp=0", carry_out); end
    @(negedge clk_in);
  endtask

  task automatic test_back_to_back;
    int cyc, first, second;
    out_ready = 1'b1;
    a_in = 16'h00FF; b_in = 16'h0001; c_in = 1'b0; in_valid = 1'b1;
    first = -1; second = -1;
    for (cyc = 0; cyc < 20 && second < 0; cyc++) begin
      @(negedge clk_in);
      if (out_valid) begin
        checks++; if (sum_out !== 16'h0100) begin failures++; $display("FAIL b2b_sum cyc=%0d got=%h exp=0100", cyc, sum_out); end
        if (first < 0) first = cyc; else second = cyc;
      end
    end
    in_valid = 1'b0;
    checks++; if (second - first != N + 2 || first < 0 || second < 0)
      begin failures++; $display("FAIL b2b_period got=%0d exp=%0d", second - first, N + 2); end
    @(negedge clk_in);
    @(negedge clk_in);
  endtask

`ifdef OVERFLOW_FLAG_EN
  task automatic test_overflow;
    int lat;
    out_ready = 1'b1;
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    checks++; if (sum_out !== 16'h8000) begin failures++; $display("FAIL ovf_sum got=%h exp=8000", sum_out); end
    checks++; if (carry_out !== 1'b0)   begin failures++; $display("FAIL ovf_carry got=%b exp=0", carry_out); end
    checks++; if (ovf_out !== 1'b1)     begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf_out); end
    @(negedge clk_in);
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if (ovf_out !== 1'b0)     begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf_out); end
    @(negedge clk_in);
  endtask
`endif

  initial begin
    test_reset;
    test_wrap;
    test_carry_in;
    test_backpressure;
    test_reset_abort;
    test_ignore_in_valid;
    test_back_to_back;
`ifdef OVERFLOW_FLAG_EN
    test_overflow;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
